regfile_dump_reader: RTL and testbench

- Debug/test readout engine for the 32x32 register file.
- On a start command it scans an inclusive register index range through the register file's two asynchronous read ports, two registers per read cycle.
- Each captured word is streamed out over a valid/ready interface to a trace/UART/testbench sink.
- It sits beside the core and shares the A1/A2 read-address muxes when debug mode is active.

---
 rtl/regfile_dump_reader.sv | 129 ++++++++++++
 tb/tb_regfile_dump_reader.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_dump_reader.sv
// Debug readout engine: scans an inclusive register range two at a time through the
// register file read ports and streams each word out over valid/ready.
module regfile_dump_reader #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_REGS = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] first_idx,
    input  logic [ADDR_W-1:0] last_idx,
    output logic [ADDR_W-1:0] rf_A1,
    output logic [ADDR_W-1:0] rf_A2,
    input  logic [DATA_W-1:0] rf_RD1,
    input  logic [DATA_W-1:0] rf_RD2,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_idx,
    output logic              out_last,
    output logic              busy,
    output logic              done,
    output logic              range_err
);

    typedef enum logic [1:0] {IDLE, READ, SEND, DONE} state_t;

    localparam logic [ADDR_W:0] LAST_LEGAL = (ADDR_W+1)'(NUM_REGS - 1);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   cur_idx_q, cur_idx_d;
    logic [ADDR_W-1:0]   end_idx_q, end_idx_d;
    logic                sel_q, sel_d;
    logic [1:0]          cnt_q, cnt_d;
    logic                err_q, err_d;
    logic [DATA_W-1:0]   buf0_q, buf0_d;
    logic [DATA_W-1:0]   buf1_q, buf1_d;
    logic [ADDR_W-1:0]   cur_pos;
    logic                is_last;
    logic                xfer;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cur_idx_q <= '0;
            end_idx_q <= '0;
            sel_q     <= 1'b0;
            cnt_q     <= '0;
            err_q     <= 1'b0;
            buf0_q    <= '0;
            buf1_q    <= '0;
        end else begin
            state_q   <= state_d;
            cur_idx_q <= cur_idx_d;
            end_idx_q <= end_idx_d;
            sel_q     <= sel_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
            buf0_q    <= buf0_d;
            buf1_q    <= buf1_d;
        end
    end

    assign cur_pos = cur_idx_q + ADDR_W'(sel_q);
    assign is_last = (cur_pos == end_idx_q);
    assign xfer    = (state_q == SEND) && out_ready;

    always_comb begin
        state_d   = state_q;
        cur_idx_d = cur_idx_q;
        end_idx_d = end_idx_q;
        sel_d     = sel_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        buf0_d    = buf0_q;
        buf1_d    = buf1_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    cur_idx_d = first_idx;
                    end_idx_d = last_idx;
                    if ((first_idx > last_idx) || ({1'b0, last_idx} > LAST_LEGAL)) begin
                        err_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        state_d = READ;
                    end
                end
            end
            READ: begin
                buf0_d  = rf_RD1;
                buf1_d  = rf_RD2;
                cnt_d   = (cur_idx_q == end_idx_q) ? 2'd1 : 2'd2;
                sel_d   = 1'b0;
                state_d = SEND;
            end
            SEND: begin
                if (xfer) begin
                    // Second word of a pair is still buffered: emit it before the next read
                    if (!sel_q && (cnt_q == 2'd2)) begin
                        sel_d = 1'b1;
                    end else if (is_last) begin
                        state_d = DONE;
                    end else begin
                        cur_idx_d = cur_idx_q + ADDR_W'(2);
                        state_d   = READ;
                    end
                end
            end
            DONE: begin
                err_d   = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign rf_A1     = cur_idx_q;
    assign rf_A2     = cur_idx_q + ADDR_W'(1);
    assign out_valid = (state_q == SEND);
    assign out_data  = out_valid ? (sel_q ? buf1_q : buf0_q) : '0;
    assign out_idx   = out_valid ? cur_pos : '0;
    assign out_last  = out_valid && is_last;
    assign busy      = (state_q == READ) || (state_q == SEND);
    assign done      = (state_q == DONE);
    assign range_err = (state_q == DONE) && err_q;

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Scoreboard bench for regfile_dump_reader against a behavioural 32x32 register file.
module tb_regfile_dump_reader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [4:0]  first_idx, last_idx;
    logic [4:0]  rf_A1, rf_A2;
    logic [31:0] rf_RD1, rf_RD2;
    logic        out_valid, out_ready, out_last, busy, done, range_err;
    logic [31:0] out_data;
    logic [4:0]  out_idx;

    logic [31:0] rf [32];
    assign rf_RD1 = rf[rf_A1];
    assign rf_RD2 = rf[rf_A2];

    regfile_dump_reader #(.DATA_W(32), .ADDR_W(5), .NUM_REGS(32)) dut (
        .clk(clk), .rst(rst), .start(start), .first_idx(first_idx), .last_idx(last_idx),
        .rf_A1(rf_A1), .rf_A2(rf_A2), .rf_RD1(rf_RD1), .rf_RD2(rf_RD2),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_idx(out_idx), .out_last(out_last), .busy(busy), .done(done),
        .range_err(range_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] data;
        logic [4:0]  idx;
        logic        last;
    } exp_t;

    exp_t sb[$];
    exp_t m_e;
    exp_t held;
    logic stall_prev = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int xfer_cnt = 0;
    int last_xfer_cyc = 0;
    int done_cnt = 0;
    int busy_cnt = 0;
    logic err_at_done = 1'b0;
    int start_edge = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc++;

    // Monitor: compare each handshake against the scoreboard and verify hold-while-stalled
    always @(negedge clk) begin
        if (rst) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                chk("hold_valid", 64'(out_valid), 64'd1);
                chk("hold_word", 64'({out_data, out_idx, out_last}), 64'(held));
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_word", 64'(out_idx), 64'hFFFF);
                end else begin
                    m_e = sb.pop_front();
                    chk("word_data", 64'(out_data), 64'(m_e.data));
                    chk("word_idx", 64'(out_idx), 64'(m_e.idx));
                    chk("word_last", 64'(out_last), 64'(m_e.last));
                end
                xfer_cnt++;
                last_xfer_cyc = cyc;
            end
            stall_prev = out_valid && !out_ready;
            held = {out_data, out_idx, out_last};
            if (done) begin
                done_cnt++;
                err_at_done = range_err;
            end
            if (busy) busy_cnt++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [4:0] f, input logic [4:0] l);
        if (f <= l) begin
            for (int i = int'(f); i <= int'(l); i++)
                sb.push_back({rf[i], 5'(i), (i == int'(l))});
        end
        first_idx = f;
        last_idx  = l;
        start     = 1'b1;
        tick();
        start_edge = cyc;
        start      = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int d0 = done_cnt;
        for (int i = 0; i < budget && done_cnt == d0; i++) tick();
        chk(tag, 64'(done_cnt - d0), 64'd1);
    endtask

    task automatic wait_word(input string tag, input logic [4:0] idx, input int budget);
        int k = 0;
        while (!(out_valid && out_idx == idx) && k < budget) begin
            tick();
            k++;
        end
        chk(tag, 64'(out_valid && out_idx == idx), 64'd1);
    endtask

    initial begin
        int x0, b0, d0;
        logic [5:0] rdy_pat;
        for (int i = 0; i < 32; i++) rf[i] = 32'hA500_0000 | 32'(i);
        rst = 1'b1; start = 1'b0; first_idx = '0; last_idx = '0; out_ready = 1'b1;
        tick(); tick();
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_err", 64'(range_err), 64'd0);
        chk("rst_a1", 64'(rf_A1), 64'd0);
        chk("rst_a2", 64'(rf_A2), 64'd1);
        chk("rst_data", 64'(out_data), 64'd0);
        rst = 1'b0;
        tick();

        // Full dump with ready held high
        x0 = xfer_cnt;
        do_start(5'd0, 5'd31);
        wait_done("full_done", 200);
        chk("full_count", 64'(xfer_cnt - x0), 64'd32);
        chk("full_latency", 64'(last_xfer_cyc + 1 - start_edge), 64'd48);
        chk("full_err", 64'(err_at_done), 64'd0);
        chk("full_sb_empty", 64'(sb.size()), 64'd0);
        tick();

        // Single-register range
        rf[7] = 32'hDEAD_BEEF;
        x0 = xfer_cnt;
        do_start(5'd7, 5'd7);
        wait_done("single_done", 20);
        chk("single_count", 64'(xfer_cnt - x0), 64'd1);
        chk("single_err", 64'(err_at_done), 64'd0);
        tick();

        // Backpressure pattern
        x0 = xfer_cnt;
        out_ready = 1'b0;
        rdy_pat = 6'b110100;
        do_start(5'd4, 5'd6);
        for (int i = 0; i < 6; i++) begin
            out_ready = rdy_pat[i];
            tick();
        end
        out_ready = 1'b1;
        wait_done("bp_done", 40);
        chk("bp_count", 64'(xfer_cnt - x0), 64'd3);
        tick();

        // Illegal range
        x0 = xfer_cnt; b0 = busy_cnt;
        do_start(5'd10, 5'd3);
        wait_done("illegal_done", 10);
        chk("illegal_err", 64'(err_at_done), 64'd1);
        chk("illegal_no_words", 64'(xfer_cnt - x0), 64'd0);
        chk("illegal_no_busy", 64'(busy_cnt - b0), 64'd0);
        tick();

        // Snapshot: R3 rewritten while pair 2/3 is stalled, start pulses ignored
        out_ready = 1'b0;
        x0 = xfer_cnt; d0 = done_cnt;
        do_start(5'd0, 5'd5);
        for (int i = 0; i < 8; i++) begin
            out_ready = (i % 2 == 0);
            if (out_valid && out_idx == 5'd2) out_ready = 1'b0;
            tick();
            if (out_valid && out_idx == 5'd2) break;
        end
        out_ready = 1'b0;
        wait_word("snap_reach_2", 5'd2, 20);
        rf[3] = 32'h0000_1234;
        first_idx = 5'd20; last_idx = 5'd21; start = 1'b1;
        tick(); tick();
        start = 1'b0;
        out_ready = 1'b1;
        wait_done("snap_done", 40);
        chk("snap_count", 64'(xfer_cnt - x0), 64'd6);
        chk("snap_one_done", 64'(done_cnt - d0), 64'd1);
        chk("snap_sb_empty", 64'(sb.size()), 64'd0);
        tick(); tick();
        chk("snap_no_restart", 64'(busy), 64'd0);

        // Reset in the middle of a dump
        d0 = done_cnt;
        do_start(5'd0, 5'd31);
        wait_word("rst_reach_9", 5'd9, 40);
        rst = 1'b1;
        tick();
        chk("midrst_valid", 64'(out_valid), 64'd0);
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_done", 64'(done), 64'd0);
        rst = 1'b0;
        sb.delete();
        tick(); tick();
        chk("midrst_no_done", 64'(done_cnt - d0), 64'd0);
        x0 = xfer_cnt;
        do_start(5'd0, 5'd1);
        wait_done("after_rst_done", 20);
        chk("after_rst_count", 64'(xfer_cnt - x0), 64'd2);
        chk("final_sb_empty", 64'(sb.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
